// File: rtl/pulse_meter_if.sv
// Pulse meter bus: arm/pulse/ack requests and the measured result.
//   arm      - level request to measure the next high pulse
//   pulse    - synchronous signal whose high time is measured
//   ack      - consumer acknowledge of a presented result
//   count    - measured high time in clk cycles
//   valid    - result on count/overflow/timeout is presented
//   overflow - measurement saturated
//   timeout  - armed wait expired without a rising edge
//   busy     - armed or measuring
interface pulse_meter_if #(
    parameter int unsigned WIDTH = 32
);
    logic             arm;
    logic             pulse;
    logic             ack;
    logic [WIDTH-1:0] count;
    logic             valid;
    logic             overflow;
    logic             timeout;
    logic             busy;

    // Side that drives requests and consumes results
    modport master (
        output arm, pulse, ack,
        input  count, valid, overflow, timeout, busy
    );

    // The meter itself
    modport slave (
        input  arm, pulse, ack,
        output count, valid, overflow, timeout, busy
    );
endinterface

// File: rtl/pulse_meter.sv
// Pulse meter: on request, measures the high time of the next pulse in clk
// cycles and holds the result until acknowledged.
//   clk   - single clock, rising edge
//   reset - asynchronous active-low reset
//   bus   - pulse_meter_if slave modport (arm/pulse/ack in, result out)
// WIDTH sets the count/counter width; TIMEOUT (0 = off) bounds the armed wait.
module pulse_meter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 0
) (
    input logic          clk,
    input logic          reset,
    pulse_meter_if.slave bus
);

    localparam int unsigned WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WIDTH-1:0] CYC_MAX = '1;

    typedef enum logic [1:0] {
        READY     = 2'd0,
        ARMED     = 2'd1,
        MEASURING = 2'd2,
        STOPPED   = 2'd3
    } state_t;

    state_t            state;
    logic              pulse_q;
    logic [WIDTH-1:0]  cycles;
    logic              sticky;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WIDTH-1:0]  count_q;
    logic              overflow_q;
    logic              timeout_q;

    logic              rise;
    logic [WAIT_W-1:0] wait_next;

    assign rise      = bus.pulse & ~pulse_q;
    assign wait_next = wait_cnt + WAIT_W'(1);

    // Control FSM and result registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= READY;
            // Held high so a pulse high across reset release is not an edge
            pulse_q    <= 1'b1;
            cycles     <= '0;
            sticky     <= 1'b0;
            wait_cnt   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            pulse_q <= bus.pulse;
            case (state)
                READY: begin
                    cycles   <= '0;
                    sticky   <= 1'b0;
                    wait_cnt <= '0;
                    if (bus.arm) begin
                        state <= ARMED;
                    end
                end
                ARMED: begin
                    // Cancel beats a same-cycle edge, which beats timeout
                    if (!bus.arm) begin
                        state    <= READY;
                        wait_cnt <= '0;
                    end else if (rise) begin
                        state    <= MEASURING;
                        cycles   <= WIDTH'(1);
                        wait_cnt <= '0;
                    end else if (TIMEOUT != 0) begin
                        if (wait_next == WAIT_W'(TIMEOUT)) begin
                            state      <= STOPPED;
                            count_q    <= '0;
                            overflow_q <= 1'b0;
                            timeout_q  <= 1'b1;
                            wait_cnt   <= '0;
                        end else begin
                            wait_cnt <= wait_next;
                        end
                    end
                end
                MEASURING: begin
                    if (bus.pulse) begin
                        if (cycles == CYC_MAX) begin
                            sticky <= 1'b1;
                        end else begin
                            cycles <= cycles + WIDTH'(1);
                        end
                    end else begin
                        state      <= STOPPED;
                        count_q    <= cycles;
                        overflow_q <= sticky;
                        timeout_q  <= 1'b0;
                    end
                end
                STOPPED: begin
                    cycles   <= '0;
                    sticky   <= 1'b0;
                    wait_cnt <= '0;
                    // arm is ignored here; it must be seen again in READY
                    if (bus.ack) begin
                        state <= READY;
                    end
                end
                default: begin
                    state <= READY;
                end
            endcase
        end
    end

    // Status decoded from the state register
    assign bus.valid    = (state == STOPPED);
    assign bus.busy     = (state == ARMED) || (state == MEASURING);
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;
    assign bus.timeout  = timeout_q;

endmodule

// File: tb/tb_pulse_meter.sv
// Directed bench for pulse_meter: a vector table for the basic flows on a
// default instance, plus hand sequences for reset, saturation (WIDTH=4) and
// timeout (TIMEOUT=10) on a second instance sharing the same stimulus.
module tb_pulse_meter;

    logic clk;
    logic reset;
    logic arm;
    logic pulse;
    logic ack;

    int n_vec;
    int n_bad;

    pulse_meter_if #(.WIDTH(32)) if0 ();
    pulse_meter_if #(.WIDTH(4))  if1 ();

    assign if0.arm   = arm;
    assign if0.pulse = pulse;
    assign if0.ack   = ack;
    assign if1.arm   = arm;
    assign if1.pulse = pulse;
    assign if1.ack   = ack;

    pulse_meter #(.WIDTH(32), .TIMEOUT(0)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0)
    );

    pulse_meter #(.WIDTH(4), .TIMEOUT(10)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        arm;
        logic        pulse;
        logic        ack;
        logic        e_valid;
        logic        e_busy;
        logic [31:0] e_count;
        logic        e_ovf;
        logic        e_to;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock and sample just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check0(input string tag, input logic v, input logic b,
                          input logic [31:0] c, input logic o, input logic t);
        check({tag, ".valid"},    32'(if0.valid),    32'(v));
        check({tag, ".busy"},     32'(if0.busy),     32'(b));
        check({tag, ".count"},    if0.count,         c);
        check({tag, ".overflow"}, 32'(if0.overflow), 32'(o));
        check({tag, ".timeout"},  32'(if0.timeout),  32'(t));
    endtask

    task automatic check1(input string tag, input logic v, input logic b,
                          input logic [31:0] c, input logic o, input logic t);
        check({tag, ".valid"},    32'(if1.valid),    32'(v));
        check({tag, ".busy"},     32'(if1.busy),     32'(b));
        check({tag, ".count"},    32'(if1.count),    c);
        check({tag, ".overflow"}, 32'(if1.overflow), 32'(o));
        check({tag, ".timeout"},  32'(if1.timeout),  32'(t));
    endtask

    initial begin
        bit hold_ok;
        n_vec = 0;
        n_bad = 0;

        // arm pulse ack | valid busy count ovf to
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0}; // -> ARMED
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0}; // edge, 1
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0}; // 2
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0}; // 3, arm ignored
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0}; // 4
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0}; // 5
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd5, 1'b0, 1'b0}; // STOPPED
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd5, 1'b0, 1'b0}; // ack -> READY
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd5, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd5, 1'b0, 1'b0}; // pre-high
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'd5, 1'b0, 1'b0}; // ARMED
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'd5, 1'b0, 1'b0}; // no edge
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd5, 1'b0, 1'b0}; // falls
        vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'd5, 1'b0, 1'b0}; // edge, 1
        vecs[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'd5, 1'b0, 1'b0}; // 2
        vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'd5, 1'b0, 1'b0}; // 3
        vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd3, 1'b0, 1'b0}; // STOPPED
        vecs[17] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd3, 1'b0, 1'b0}; // arm+ack -> READY
        vecs[18] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd3, 1'b0, 1'b0}; // ARMED
        vecs[19] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd3, 1'b0, 1'b0}; // cancel wins
        vecs[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd3, 1'b0, 1'b0};

        // Reset state
        reset = 1'b0;
        arm   = 1'b0;
        pulse = 1'b0;
        ack   = 1'b0;
        step();
        step();
        check0("reset0", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        check1("reset1", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        reset = 1'b1;
        step();

        // Table-driven basic flows on the default instance
        for (int i = 0; i < NV; i++) begin
            arm   = vecs[i].arm;
            pulse = vecs[i].pulse;
            ack   = vecs[i].ack;
            step();
            check0($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_busy,
                   vecs[i].e_count, vecs[i].e_ovf, vecs[i].e_to);
        end

        // Reset in the middle of a measurement
        arm   = 1'b1;
        pulse = 1'b0;
        step();
        pulse = 1'b1;
        step();
        step();
        check("mid.busy_before", 32'(if0.busy), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check0("mid.async", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        step();
        reset = 1'b1;                 // pulse still high across release
        step();                       // READY -> ARMED
        step();                       // high but no edge
        pulse = 1'b0;
        step();
        check0("mid.not_measured", 1'b0, 1'b1, 32'd0, 1'b0, 1'b0);
        pulse = 1'b1;
        step();
        step();
        pulse = 1'b0;
        step();
        check0("mid.after", 1'b1, 1'b0, 32'd2, 1'b0, 1'b0);
        arm = 1'b0;
        ack = 1'b1;
        step();
        ack = 1'b0;

        // Saturation: 20 high cycles, 4-bit instance clips at 15
        arm = 1'b1;
        step();
        pulse = 1'b1;
        for (int k = 0; k < 20; k++) step();
        pulse = 1'b0;
        step();
        check1("sat1", 1'b1, 1'b0, 32'd15, 1'b1, 1'b0);
        check0("sat0", 1'b1, 1'b0, 32'd20, 1'b0, 1'b0);
        arm = 1'b0;
        ack = 1'b1;
        step();
        ack = 1'b0;
        check1("sat1.ack", 1'b0, 1'b0, 32'd15, 1'b1, 1'b0);

        // Timeout: 10 cycles in ARMED with no edge
        arm = 1'b1;
        step();                       // -> ARMED
        for (int k = 0; k < 9; k++) step();
        check1("to.armed10", 1'b0, 1'b1, 32'd15, 1'b1, 1'b0);
        step();
        check1("to.expired", 1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
        check0("to.disabled", 1'b0, 1'b1, 32'd20, 1'b0, 1'b0);

        // Result held while ack is withheld
        hold_ok = 1'b1;
        for (int k = 0; k < 50; k++) begin
            step();
            if (!(if1.valid === 1'b1 && if1.count === 4'd0 && if1.timeout === 1'b1))
                hold_ok = 1'b0;
        end
        check("hold.stable", 32'(hold_ok), 32'd1);

        // arm together with ack returns to READY, not ARMED
        ack = 1'b1;
        step();
        ack = 1'b0;
        check1("ackarm", 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        arm = 1'b0;
        step();
        check1("ready", 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
